// File: rtl/raster_pkg.sv
// Shared definitions for the raster sample sequencer: state encoding, default
// coordinate width and the edge-function inside test.
package raster_pkg;

    localparam int CW_DEFAULT = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_STEP   = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ISSUE  = ST_ISSUE,
        S_WAIT   = ST_WAIT,
        S_EMIT   = ST_EMIT,
        S_STEP   = ST_STEP,
        S_FINISH = ST_FINISH
    } state_t;

    // incl=1 keeps samples lying exactly on an edge; incl=0 rejects them.
    function automatic logic is_inside(input logic signed [31:0] e1,
                                       input logic signed [31:0] e2,
                                       input logic signed [31:0] e3,
                                       input logic               incl);
        if (incl)
            return (e1 >= 0) && (e2 >= 0) && (e3 >= 0);
        else
            return (e1 > 0) && (e2 > 0) && (e3 > 0);
    endfunction

endpackage

// File: rtl/raster_step.sv
// Combinational next-sample coordinate for a row-major walk over an inclusive
// signed box; sums carry one extra bit so the top of the range never wraps negative.
module raster_step
    import raster_pkg::*;
#(
    parameter int                    W    = CW_DEFAULT,
    parameter logic signed [W-1:0]   STEP = 1
) (
    input  logic signed [W-1:0] px,
    input  logic signed [W-1:0] py,
    input  logic signed [W-1:0] xmin,
    input  logic signed [W-1:0] xmax,
    input  logic signed [W-1:0] ymax,
    output logic signed [W-1:0] nx,
    output logic signed [W-1:0] ny,
    output logic                row_wrap,
    output logic                last
);

    logic signed [W:0] sum_x;
    logic signed [W:0] sum_y;
    logic              x_ovf;
    logic              y_ovf;

    assign sum_x = $signed({px[W-1], px}) + $signed({STEP[W-1], STEP});
    assign sum_y = $signed({py[W-1], py}) + $signed({STEP[W-1], STEP});
    assign x_ovf = sum_x[W] ^ sum_x[W-1];
    assign y_ovf = sum_y[W] ^ sum_y[W-1];

    assign row_wrap = x_ovf || (sum_x > $signed({xmax[W-1], xmax}));
    assign last     = row_wrap && (y_ovf || (sum_y > $signed({ymax[W-1], ymax})));
    assign nx       = row_wrap ? xmin : sum_x[W-1:0];
    assign ny       = row_wrap ? sum_y[W-1:0] : py;

endmodule

// File: rtl/raster_scan_ctrl.sv
// Walks a triangle's bounding box, issues one edge evaluation per sample and
// forwards covered samples as fragments.
module raster_scan_ctrl
    import raster_pkg::*;
#(
    parameter int                  CW   = CW_DEFAULT,
    parameter logic signed [CW-1:0] STEP = 16'sd1,
    parameter bit                  INCL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    input  logic signed [CW-1:0] bb_xmin,
    input  logic signed [CW-1:0] bb_xmax,
    input  logic signed [CW-1:0] bb_ymin,
    input  logic signed [CW-1:0] bb_ymax,
    output logic                 ef_valid,
    output logic signed [CW-1:0] ef_px,
    output logic signed [CW-1:0] ef_py,
    input  logic                 ef_done,
    input  logic signed [31:0]   ef_e1,
    input  logic signed [31:0]   ef_e2,
    input  logic signed [31:0]   ef_e3,
    output logic                 frag_valid,
    input  logic                 frag_ready,
    output logic signed [CW-1:0] frag_x,
    output logic signed [CW-1:0] frag_y,
    output logic signed [31:0]   frag_e1,
    output logic signed [31:0]   frag_e2,
    output logic signed [31:0]   frag_e3,
    output logic                 tri_done,
    output logic [15:0]          n_tested,
    output logic [15:0]          n_frags,
    output logic [2:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; a valid source holds its payload until that edge.

    state_t               state;
    logic signed [CW-1:0] xmin_r;
    logic signed [CW-1:0] xmax_r;
    logic signed [CW-1:0] ymax_r;
    logic signed [CW-1:0] nx;
    logic signed [CW-1:0] ny;
    logic                 row_wrap;
    logic                 last;

    assign dbg_state = state;

    raster_step #(.W(CW), .STEP(STEP)) u_step (
        .px       (ef_px),
        .py       (ef_py),
        .xmin     (xmin_r),
        .xmax     (xmax_r),
        .ymax     (ymax_r),
        .nx       (nx),
        .ny       (ny),
        .row_wrap (row_wrap),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tri_ready  <= 1'b1;
            ef_valid   <= 1'b0;
            ef_px      <= '0;
            ef_py      <= '0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_e1    <= '0;
            frag_e2    <= '0;
            frag_e3    <= '0;
            tri_done   <= 1'b0;
            n_tested   <= '0;
            n_frags    <= '0;
            xmin_r     <= '0;
            xmax_r     <= '0;
            ymax_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tri_valid) begin
                        xmin_r    <= bb_xmin;
                        xmax_r    <= bb_xmax;
                        ymax_r    <= bb_ymax;
                        ef_px     <= bb_xmin;
                        ef_py     <= bb_ymin;
                        n_tested  <= '0;
                        n_frags   <= '0;
                        tri_ready <= 1'b0;
                        // An empty box finishes without touching the edge unit.
                        if ((bb_xmin > bb_xmax) || (bb_ymin > bb_ymax)) begin
                            state    <= S_FINISH;
                            tri_done <= 1'b1;
                        end else begin
                            state    <= S_ISSUE;
                            ef_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    ef_valid <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (ef_done) begin
                        frag_e1  <= ef_e1;
                        frag_e2  <= ef_e2;
                        frag_e3  <= ef_e3;
                        n_tested <= (n_tested == 16'hFFFF) ? n_tested : n_tested + 16'd1;
                        if (is_inside(ef_e1, ef_e2, ef_e3, INCL)) begin
                            frag_valid <= 1'b1;
                            frag_x     <= ef_px;
                            frag_y     <= ef_py;
                            state      <= S_EMIT;
                        end else begin
                            state <= S_STEP;
                        end
                    end
                end
                S_EMIT: begin
                    if (frag_ready) begin
                        frag_valid <= 1'b0;
                        n_frags    <= (n_frags == 16'hFFFF) ? n_frags : n_frags + 16'd1;
                        state      <= S_STEP;
                    end
                end
                S_STEP: begin
                    ef_px <= nx;
                    ef_py <= ny;
                    if (last) begin
                        tri_done <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        ef_valid <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    tri_done  <= 1'b0;
                    tri_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    tri_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: a sample-list model of the box walk and an edge
// responder drive the DUT; one negedge process checks every handshake.
module tb_raster_scan_ctrl;

    typedef struct {
        int x;
        int y;
    } pt_t;

    typedef struct {
        int x;
        int y;
        int e1;
        int e2;
        int e3;
    } frag_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (INCL=1) ----------------
    logic               tri_valid = 1'b0;
    logic               tri_ready;
    logic signed [15:0] bb_xmin = '0, bb_xmax = '0, bb_ymin = '0, bb_ymax = '0;
    logic               ef_valid;
    logic signed [15:0] ef_px, ef_py;
    logic               ef_done = 1'b0;
    logic signed [31:0] ef_e1 = '0, ef_e2 = '0, ef_e3 = '0;
    logic               frag_valid;
    logic               frag_ready = 1'b1;
    logic signed [15:0] frag_x, frag_y;
    logic signed [31:0] frag_e1, frag_e2, frag_e3;
    logic               tri_done;
    logic [15:0]        n_tested, n_frags;
    logic [2:0]         dbg_state;

    raster_scan_ctrl #(.CW(16), .STEP(16'sd1), .INCL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
        .ef_valid(ef_valid), .ef_px(ef_px), .ef_py(ef_py), .ef_done(ef_done),
        .ef_e1(ef_e1), .ef_e2(ef_e2), .ef_e3(ef_e3),
        .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
        .frag_e1(frag_e1), .frag_e2(frag_e2), .frag_e3(frag_e3),
        .tri_done(tri_done), .n_tested(n_tested), .n_frags(n_frags), .dbg_state(dbg_state)
    );

    // ---------------- second DUT (INCL=0) ----------------
    logic               tri_valid0 = 1'b0;
    logic               tri_ready0;
    logic               ef_valid0;
    logic signed [15:0] ef_px0, ef_py0;
    logic               ef_done0 = 1'b0;
    logic signed [31:0] ef_e1_0 = '0, ef_e2_0 = '0, ef_e3_0 = '0;
    logic               frag_valid0;
    logic signed [15:0] frag_x0, frag_y0;
    logic signed [31:0] frag_e1_0, frag_e2_0, frag_e3_0;
    logic               tri_done0;
    logic [15:0]        n_tested0, n_frags0;
    logic [2:0]         dbg_state0;

    raster_scan_ctrl #(.CW(16), .STEP(16'sd1), .INCL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid0), .tri_ready(tri_ready0),
        .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
        .ef_valid(ef_valid0), .ef_px(ef_px0), .ef_py(ef_py0), .ef_done(ef_done0),
        .ef_e1(ef_e1_0), .ef_e2(ef_e2_0), .ef_e3(ef_e3_0),
        .frag_valid(frag_valid0), .frag_ready(1'b1), .frag_x(frag_x0), .frag_y(frag_y0),
        .frag_e1(frag_e1_0), .frag_e2(frag_e2_0), .frag_e3(frag_e3_0),
        .tri_done(tri_done0), .n_tested(n_tested0), .n_frags(n_frags0), .dbg_state(dbg_state0)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;

    pt_t   sample_q[$];
    frag_t exp_q[$];
    int    exp_tested = 0;
    int    tri_id = 0;
    int    mode = 0;
    int    seed = 0;
    int    stall_cfg = 0;
    bit    rand_ready = 1'b0;
    bit    rsp_fixed = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge values a well-behaved edge unit would return for each test mode.
    function automatic void edge_fn(input int x, input int y, input int md,
                                    output int e1, output int e2, output int e3);
        case (md)
            1: begin e1 = x; e2 = (x == 1) ? -1 : y; e3 = x + y + 1; end
            2: begin e1 = (x == 0) ? 0 : 1; e2 = 1; e3 = 1; end
            3: begin
                e1 = ((x * 3 + y * 5 + seed) % 7) - 2;
                e2 = ((x * 5 + y + seed) % 5) - 1;
                e3 = ((x + y * 7 + seed) % 6) - 1;
            end
            default: begin e1 = x; e2 = y; e3 = x + y + 1; end
        endcase
    endfunction

    function automatic bit covered(input int e1, input int e2, input int e3, input bit incl);
        return incl ? (e1 >= 0 && e2 >= 0 && e3 >= 0) : (e1 > 0 && e2 > 0 && e3 > 0);
    endfunction

    // Row-major list of every sample in the inclusive box and the covered subset.
    task automatic build_model(input int xmn, input int xmx, input int ymn, input int ymx);
        int e1, e2, e3;
        pt_t p;
        frag_t f;
        sample_q.delete();
        exp_q.delete();
        for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
                p.x = x; p.y = y;
                sample_q.push_back(p);
                edge_fn(x, y, mode, e1, e2, e3);
                if (covered(e1, e2, e3, 1'b1)) begin
                    f.x = x; f.y = y; f.e1 = e1; f.e2 = e2; f.e3 = e3;
                    exp_q.push_back(f);
                end
            end
        end
        exp_tested = sample_q.size();
    endtask

    // ---------------- edge responder + compare process ----------------
    int seen_id = 0;
    int rd_ptr = 0, sp_ptr = 0;
    int ef_cnt = 0, frag_cnt = 0, done_cnt = 0, stall_seen = 0, stall_left = 0;
    bit pending = 1'b0, discard = 1'b0, prev_hold = 1'b0;
    int delay = 0, hold_x = 0, hold_y = 0;
    logic [127:0] snap = '0;

    always @(negedge clk) begin
        int e1, e2, e3;
        frag_t f;
        if (tri_id != seen_id) begin
            seen_id = tri_id; rd_ptr = 0; sp_ptr = 0;
            ef_cnt = 0; frag_cnt = 0; done_cnt = 0; stall_seen = 0;
            stall_left = stall_cfg;
        end
        ef_done = 1'b0;
        if (!rst_n && pending) discard = 1'b1;

        if (ef_valid) begin
            ef_cnt++;
            check("ef_while_outstanding", {31'd0, pending}, 128'd0);
            if (sp_ptr < sample_q.size())
                check("ef_coord", {ef_px, ef_py}, {sample_q[sp_ptr].x[15:0], sample_q[sp_ptr].y[15:0]});
            else
                check("ef_extra_sample", sp_ptr, sample_q.size());
            sp_ptr++;
            pending = 1'b1;
            delay = rsp_fixed ? 3 : $urandom_range(1, 3);
            hold_x = ef_px; hold_y = ef_py;
        end else if (pending) begin
            delay--;
            if (delay == 0) begin
                if (!discard)
                    check("ef_coord_hold", {ef_px, ef_py}, {hold_x[15:0], hold_y[15:0]});
                edge_fn(hold_x, hold_y, mode, e1, e2, e3);
                ef_e1 = e1; ef_e2 = e2; ef_e3 = e3;
                ef_done = 1'b1;
                pending = 1'b0;
                discard = 1'b0;
            end
        end

        if (frag_valid && stall_left > 0) begin
            frag_ready = 1'b0;
            stall_left--;
            stall_seen++;
        end else begin
            frag_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end

        if (frag_valid) begin
            if (prev_hold)
                check("frag_stable", {frag_x, frag_y, frag_e1, frag_e2, frag_e3}, snap);
            if (!frag_ready) begin
                check("no_ef_during_emit", {127'd0, ef_valid}, 128'd0);
                prev_hold = 1'b1;
                snap = {frag_x, frag_y, frag_e1, frag_e2, frag_e3};
            end else begin
                prev_hold = 1'b0;
                frag_cnt++;
                if (rd_ptr < exp_q.size()) begin
                    f = exp_q[rd_ptr];
                    check("frag_xy", {frag_x, frag_y}, {f.x[15:0], f.y[15:0]});
                    check("frag_e", {frag_e1, frag_e2, frag_e3}, {f.e1, f.e2, f.e3});
                end else begin
                    check("frag_extra", rd_ptr, exp_q.size());
                end
                rd_ptr++;
            end
        end else begin
            prev_hold = 1'b0;
        end

        if (tri_done) begin
            done_cnt++;
            check("done_n_tested", n_tested, exp_tested);
            check("done_n_frags", n_frags, exp_q.size());
            check("done_all_frags", rd_ptr, exp_q.size());
            check("done_all_samples", sp_ptr, sample_q.size());
        end
    end

    // Responder and fragment log for the INCL=0 instance (mode 2 values).
    bit p0 = 1'b0;
    int hx0 = 0, frag0_cnt = 0, frag0_x = -1;
    always @(negedge clk) begin
        int e1, e2, e3;
        ef_done0 = 1'b0;
        if (ef_valid0) begin
            p0 = 1'b1; hx0 = ef_px0;
        end else if (p0) begin
            edge_fn(hx0, 0, 2, e1, e2, e3);
            ef_e1_0 = e1; ef_e2_0 = e2; ef_e3_0 = e3;
            ef_done0 = 1'b1;
            p0 = 1'b0;
        end
        if (frag_valid0) begin
            frag0_cnt++;
            frag0_x = frag_x0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Runs one triangle to completion; lat = cycles from accept to tri_done.
    task automatic run_tri(input int xmn, input int xmx, input int ymn, input int ymx,
                           input int md, input int stall, input bit rr, input bit also0,
                           output int lat);
        int guard;
        mode = md; stall_cfg = stall; rand_ready = rr;
        build_model(xmn, xmx, ymn, ymx);
        tri_id++;
        guard = 0;
        while (!tri_ready && guard < 50) begin step_cycles(1); guard++; end
        if (!tri_ready) check("tri_ready_timeout", {127'd0, tri_ready}, 128'd1);
        bb_xmin = xmn[15:0]; bb_xmax = xmx[15:0]; bb_ymin = ymn[15:0]; bb_ymax = ymx[15:0];
        tri_valid = 1'b1;
        tri_valid0 = also0;
        step_cycles(1);
        tri_valid = 1'b0;
        tri_valid0 = 1'b0;
        lat = 0;
        while (done_cnt == 0 && lat < 3000) begin step_cycles(1); lat++; end
        if (done_cnt == 0) check("tri_done_timeout", done_cnt, 1);
        step_cycles(2);
        check("one_tri_done", done_cnt, 1);
        check("ef_count", ef_cnt, sample_q.size());
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int xmn, ymn;
        step_cycles(3);
        check("rst_ctrl", {tri_ready, ef_valid, frag_valid, tri_done}, 4'b1000);
        check("rst_counts", {n_tested, n_frags}, 32'd0);
        check("rst_coords", {ef_px, ef_py, frag_x, frag_y}, 64'd0);
        rst_n = 1'b1;
        step_cycles(2);

        // full-coverage 3x2 box
        run_tri(0, 2, 0, 1, 0, 0, 1'b0, 1'b0, lat);
        check("t1_model_first", {exp_q[0].x[15:0], exp_q[0].y[15:0]}, {16'd0, 16'd0});
        check("t1_model_last", {exp_q[5].x[15:0], exp_q[5].y[15:0]}, {16'd2, 16'd1});
        check("t1_n_tested", n_tested, 16'd6);
        check("t1_n_frags", n_frags, 16'd6);
        check("t1_frag_cnt", frag_cnt, 6);

        // column x==1 rejected
        run_tri(0, 2, 0, 1, 1, 0, 1'b0, 1'b0, lat);
        check("t2_n_tested", n_tested, 16'd6);
        check("t2_n_frags", n_frags, 16'd4);

        // empty box
        run_tri(5, 4, 0, 0, 0, 0, 1'b0, 1'b0, lat);
        check("t3_latency_le2", {31'd0, lat <= 2}, 128'd1);
        check("t3_no_ef", ef_cnt, 0);
        check("t3_n_tested", n_tested, 16'd0);

        // single sample box
        run_tri(3, 3, -2, -2, 0, 0, 1'b0, 1'b0, lat);
        check("single_ef", ef_cnt, 1);

        // downstream stall of 10 cycles on the first fragment
        run_tri(0, 1, 0, 0, 0, 10, 1'b0, 1'b0, lat);
        check("t4_stall_cycles", stall_seen, 10);
        check("t4_n_frags", n_frags, 16'd2);

        // top of the coordinate range
        run_tri(32766, 32767, 0, 1, 0, 0, 1'b0, 1'b0, lat);
        check("t5_n_tested", n_tested, 16'd4);
        check("t5_frag_cnt", frag_cnt, 4);

        // on-edge sample: INCL=1 keeps it, INCL=0 drops it
        run_tri(0, 1, 0, 0, 2, 0, 1'b0, 1'b1, lat);
        step_cycles(5);
        check("t7_incl1_n_frags", n_frags, 16'd2);
        check("t7_incl0_n_tested", n_tested0, 16'd2);
        check("t7_incl0_n_frags", n_frags0, 16'd1);
        check("t7_incl0_frag_cnt", frag0_cnt, 1);
        check("t7_incl0_frag_x", frag0_x, 1);

        // randomized boxes, coverage and back-pressure
        for (int i = 0; i < 25; i++) begin
            seed = $urandom_range(0, 1000);
            xmn = $urandom_range(0, 8) - 4;
            ymn = $urandom_range(0, 8) - 4;
            run_tri(xmn, xmn + $urandom_range(0, 4) - 1, ymn, ymn + $urandom_range(0, 3) - 1,
                    3, $urandom_range(0, 3), 1'b1, 1'b0, lat);
        end

        // reset while waiting for an edge result; the late ef_done must be ignored
        mode = 0; stall_cfg = 0; rand_ready = 1'b0; rsp_fixed = 1'b1;
        build_model(0, 2, 0, 1);
        tri_id++;
        step_cycles(1);
        bb_xmin = 16'sd0; bb_xmax = 16'sd2; bb_ymin = 16'sd0; bb_ymax = 16'sd1;
        tri_valid = 1'b1;
        step_cycles(1);
        tri_valid = 1'b0;
        lat = 0;
        while (ef_cnt == 0 && lat < 20) begin step_cycles(1); lat++; end
        step_cycles(1);
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", {tri_ready, ef_valid, frag_valid}, 3'b100);
        step_cycles(1);
        rst_n = 1'b1;
        step_cycles(8);
        rsp_fixed = 1'b0;
        check("t6_no_frag", frag_cnt, 0);
        check("t6_no_done", done_cnt, 0);
        check("t6_idle", {tri_ready, frag_valid}, 2'b10);
        check("t6_counts", {n_tested, n_frags}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
